mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the MIPS core: a Moore state machine that sequences a shared-ALU, shared-memory multicycle datapath one instruction at a time, driving its register enables, mux selects and ALU control. It decodes `op`/`funct` from the instruction register and stalls on a memory ready handshake. It replaces the combinational main/ALU decoders used by the single-cycle core.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `op`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0]
- `zero`  in  1  ALU zero flag
- `memready`  in  1  memory completes the current access this cycle
- `iord`  out  1  memory address select: 0 = pc, 1 = aluout register
- `irwrite`  out  1  instruction register load
- `memwrite`  out  1  memory write strobe
- `pcen`  out  1  PC register load
- `regwrite`  out  1  register-file write
- `regdst`  out  1  write register: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback: 0 = aluout, 1 = data register
- `alusrca`  out  1  0 = pc, 1 = register A
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcsrc`  out  2  00 = ALU result, 01 = aluout register, 10 = jump target
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal`  out  1  one-cycle pulse on an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00. irwrite and pcwrite are asserted only in the cycle `memready`=1, and that cycle advances to DECODE. Otherwise FETCH holds.
- DECODE: alusrca=0, alusrcb=11, add (branch target). Dispatch:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → EXECUTE
  - beq 000100 → BRANCH
  - addi 001000 → ADDIEXEC
  - j 000010 → JUMP
  - any other opcode → FETCH, with `illegal`=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1. Holds until `memready`, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite. Then FETCH.
- MEMWR: iord=1. `memwrite` stays high for every cycle spent in MEMWR. Leaves to FETCH on `memready`.
- EXECUTE: alusrca=1, alusrcb=00, aluop=funct. Then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. Then FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, add. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite. Then FETCH.
- JUMP: pcsrc=10, pcwrite. Then FETCH.
- Outputs in states not listed above are 0.
- `pcen` = pcwrite | (branch & zero).
- ALU decode:
  - aluop add → 010; aluop sub → 110
  - funct 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111
  - unknown funct → 010, with no `illegal` pulse.

## Timing
- Outputs are combinational from state, plus `zero`, `funct` and `memready` where stated. The state register is the only storage.
- Reset: state becomes FETCH immediately.
  - While `reset` is high, irwrite, pcen, regwrite and memwrite are forced to 0 and `illegal` is 0.
  - The remaining outputs take their FETCH values.
  - Deasserting reset mid-instruction abandons that instruction; no partial write occurs after reset.
- Cycles per instruction with `memready` tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle with `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `memready` is sampled only in FETCH, MEMRD and MEMWR and ignored elsewhere.

## Configuration
- `MC_BNE_EN` defined: adds opcode 000101 (bne).
  - DECODE dispatches it to state BNE, which has the BRANCH outputs but branchne=1 and branch=0.
  - `pcen` additionally includes branchne & ~zero.
- `MC_BNE_EN` undefined: opcode 000101 is illegal; DECODE returns to FETCH and pulses `illegal`.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants
  - the state enum
  - alucontrol encodings
  - the aluop typedef (add/sub/funct)
- Sub-module `mc_aludec` is the combinational aluop+funct → alucontrol decoder.
- The FSM and output decode stay in `mc_controller`.

## Test plan
- lw (op=100011), `memready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with memtoreg=1 only in cycle 5; pcen=1 only in cycle 1.
- sw with `memready` low for 2 cycles in MEMWR → memwrite high for exactly 3 cycles, then FETCH; regwrite never asserted.
- beq (op=000100): with zero=1, pcen=1 in BRANCH with pcsrc=01; with zero=0, pcen=0. Both cases take 3 cycles.
- R-type funct=101010 → alucontrol=111 in EXECUTE; ALUWB has regdst=1, regwrite=1.
- op=000101 without `MC_BNE_EN` → `illegal`=1 for one cycle in DECODE, then FETCH. With the macro and zero=0 → pcen=1 in BNE.
- Assert reset during MEMRD → state is FETCH immediately and all write enables are 0. After release, the next fetch waits on `memready`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode/funct
// constants, FSM state encoding, ALU control encodings and the aluop type.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } aluop_e;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiExec,
    StAddiWb,
    StJump,
    StBne
  } state_e;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decoder: aluop (plus funct for R-type) -> alucontrol.
// Unknown funct codes fall back to add without flagging an error.
module mc_aludec
  import mips_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alucontrol_o
);

  // Decode the ALU operation for the current state
  always_comb begin
    alucontrol_o = AluCtlAdd;
    unique case (aluop_i)
      AluOpAdd: alucontrol_o = AluCtlAdd;
      AluOpSub: alucontrol_o = AluCtlSub;
      AluOpFunct: begin
        case (funct_i)
          FnAdd:   alucontrol_o = AluCtlAdd;
          FnSub:   alucontrol_o = AluCtlSub;
          FnAnd:   alucontrol_o = AluCtlAnd;
          FnOr:    alucontrol_o = AluCtlOr;
          FnSlt:   alucontrol_o = AluCtlSlt;
          default: alucontrol_o = AluCtlAdd;
        endcase
      end
      default: alucontrol_o = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared-ALU,
// shared-memory datapath. Stalls in FETCH/MEMRD/MEMWR until memready.
// Optional feature: define MC_BNE_EN to add the bne instruction.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pcwrite, branch, branchne;
  logic   irwrite_s, memwrite_s, regwrite_s, illegal_s;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = AluOpAdd;
    illegal_s  = 1'b0;

    unique case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        if (memready) begin
          irwrite_s = 1'b1;
          pcwrite   = 1'b1;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        alusrcb = 2'b11;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
`ifdef MC_BNE_EN
          OpBne:      state_d = StBne;
`endif
          default: begin
            state_d   = StFetch;
            illegal_s = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord = 1'b1;
        if (memready) state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        if (memready) state_d = StFetch;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = AluOpSub;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      StAddiExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        regwrite_s = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
`ifdef MC_BNE_EN
      StBne: begin
        alusrca  = 1'b1;
        aluop    = AluOpSub;
        pcsrc    = 2'b01;
        branchne = 1'b1;
        state_d  = StFetch;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // Write enables are suppressed while reset is held so nothing partial lands
  always_comb begin
    irwrite  = irwrite_s & ~reset;
    memwrite = memwrite_s & ~reset;
    regwrite = regwrite_s & ~reset;
    illegal  = illegal_s & ~reset;
`ifdef MC_BNE_EN
    pcen     = (pcwrite | (branch & zero) | (branchne & ~zero)) & ~reset;
`else
    pcen     = (pcwrite | (branch & zero) | (branchne & 1'b0)) & ~reset;
`endif
  end

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule
